// File: rtl/engine_channel_pkg.sv
// Shared types and helpers for the PC channel between vectorial engines.
// Holds the token layout and a saturating increment used by age/stat counters.
package engine_channel_pkg;

    localparam int PKG_PC_WIDTH   = 8;
    localparam int PKG_CC_ID_BITS = 1;

    typedef struct packed {
        logic [PKG_PC_WIDTH-1:0]   pc;
        logic [PKG_CC_ID_BITS-1:0] cc_id;
    } token_t;

    // Increment that sticks at 2**width-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input int unsigned width
    );
        logic [32:0] w_max;
        w_max = (33'd1 << width) - 33'd1;
        if ({1'b0, value} >= w_max) begin
            return w_max[31:0];
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/channel_iface.sv
// Valid/ready channel carrying a {pc,cc_id} token plus a latency field.
// Modports: out = producer side (drives valid/data/latency), in = consumer side.
interface channel_iface #(
    parameter int DATA_W = 9,
    parameter int LAT_W  = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [LAT_W-1:0]  latency;

    modport out (output valid, output data, output latency, input ready);
    modport in  (input valid, input data, input latency, output ready);
endinterface

// File: rtl/channel_fifo_entry.sv
// One FIFO slot: token register plus saturating age counter.
// Ports: clk, rst (async active-low), i_load (store token, age=1),
//        i_clear (free slot), i_data, o_data, o_age.
module channel_fifo_entry
    import engine_channel_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int LAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [LAT_W-1:0]  o_age
);

    logic [DATA_W-1:0] r_data;
    logic [LAT_W-1:0]  r_age;
    logic              r_used;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_age  <= '0;
            r_used <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_age  <= LAT_W'(1);
            r_used <= 1'b1;
        end else if (i_clear) begin
            r_age  <= '0;
            r_used <= 1'b0;
        end else if (r_used) begin
            r_age <= LAT_W'(sat_inc(32'(r_age), LAT_W));
        end
    end

    assign o_data = r_data;
    assign o_age  = r_age;

endmodule

// File: rtl/engine_channel_fifo.sv
// Elastic buffer between engines; regenerates latency as cycles spent queued.
// Ports: clk, rst (async active-low), in/out channels, empty, full, count.
// Optional ENGINE_CHANNEL_FIFO_STATS_EN adds max_count and stall_cycles.
module engine_channel_fifo
    import engine_channel_pkg::*;
#(
    parameter int PC_WIDTH            = PKG_PC_WIDTH,
    parameter int CC_ID_BITS          = PKG_CC_ID_BITS,
    parameter int LATENCY_COUNT_WIDTH = 8,
    parameter int FIFO_COUNT_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    channel_iface.in                  in,
    channel_iface.out                 out,
    output logic                      empty,
    output logic                      full,
`ifdef ENGINE_CHANNEL_FIFO_STATS_EN
    output logic [FIFO_COUNT_WIDTH:0] max_count,
    output logic [31:0]               stall_cycles,
`endif
    output logic [FIFO_COUNT_WIDTH:0] count
);

    localparam int DW    = PC_WIDTH + CC_ID_BITS;
    localparam int LW    = LATENCY_COUNT_WIDTH;
    localparam int FW    = FIFO_COUNT_WIDTH;
    localparam int DEPTH = 1 << FW;

    logic [FW:0]   r_wr_ptr;
    logic [FW:0]   r_rd_ptr;
    logic          r_ready;
    logic [FW:0]   w_count;
    logic [FW:0]   w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [FW-1:0] w_wr_idx;
    logic [FW-1:0] w_rd_idx;

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic [DW-1:0]    w_data [DEPTH];
    logic [LW-1:0]    w_age  [DEPTH];

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == (FW+1)'(DEPTH));
    assign w_wr_idx = r_wr_ptr[FW-1:0];
    assign w_rd_idx = r_rd_ptr[FW-1:0];

    // r_ready mirrors !full but comes from a flop, so out.ready never
    // reaches in.ready combinationally; a pop at full frees space next cycle.
    assign w_push = in.valid & r_ready;
    assign w_pop  = ~w_empty & out.ready;

    assign w_count_nxt = w_count
                       + (FW+1)'(w_push)
                       - (FW+1)'(w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ready <= (w_count_nxt != (FW+1)'(DEPTH));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_load[g]  = w_push & (w_wr_idx == FW'(g));
        assign w_clear[g] = w_pop  & (w_rd_idx == FW'(g));

        channel_fifo_entry #(
            .DATA_W (DW),
            .LAT_W  (LW)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_clear (w_clear[g]),
            .i_data  (in.data),
            .o_data  (w_data[g]),
            .o_age   (w_age[g])
        );
    end

    // Freed slots keep stale data; mask the head while empty.
    assign out.valid   = ~w_empty;
    assign out.data    = w_empty ? '0 : w_data[w_rd_idx];
    assign out.latency = w_empty ? '0 : w_age[w_rd_idx];
    assign in.ready    = r_ready;

    assign empty = w_empty;
    assign full  = w_full;
    assign count = w_count;

`ifdef ENGINE_CHANNEL_FIFO_STATS_EN
    logic [FW:0] r_max_count;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max_count <= '0;
            r_stall     <= '0;
        end else begin
            if (w_count > r_max_count) begin
                r_max_count <= w_count;
            end
            if (in.valid & ~r_ready) begin
                r_stall <= sat_inc(r_stall, 32);
            end
        end
    end

    assign max_count    = r_max_count;
    assign stall_cycles = r_stall;
`endif

endmodule
